// File: rtl/local_mem_bank_arbiter.sv
// Crossbar arbiter between NUM_REQ load/store lanes and the local memory banks.
// Decodes lane addresses, arbitrates each bank round-robin, and routes 1-cycle bank responses back.
module local_mem_bank_arbiter #(
    parameter int          NUM_REQ    = 4,
    parameter int          NUM_BANKS  = 8,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] LOCAL_BASE = 32'h0002_0000,
    parameter logic [31:0] BANK_SIZE  = 32'h0000_2000
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ-1:0]                   req_we_i,
    input  logic [NUM_REQ-1:0][31:0]             req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [NUM_REQ-1:0][3:0]              req_be_i,
    output logic [NUM_REQ-1:0]                   rsp_valid_o,
    output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic [NUM_REQ-1:0]                   rsp_err_o,
    output logic [NUM_BANKS-1:0]                 bank_req_o,
    output logic [NUM_BANKS-1:0]                 bank_we_o,
    output logic [NUM_BANKS-1:0][10:0]           bank_addr_o,
    output logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_wdata_o,
    output logic [NUM_BANKS-1:0][3:0]            bank_be_o,
    input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata_i
);

    localparam int          LW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          BW     = $clog2(NUM_BANKS);
    localparam int          OW     = $clog2(BANK_SIZE);
    localparam logic [31:0] WINDOW = 32'(NUM_BANKS) * BANK_SIZE;

    logic [NUM_REQ-1:0][31:0]          off;
    logic [NUM_REQ-1:0]                in_range;
    logic [NUM_REQ-1:0][BW-1:0]        lane_bank;
    logic [NUM_REQ-1:0][10:0]          lane_word;
    logic [NUM_REQ-1:0][NUM_BANKS-1:0] cand;

    logic [NUM_BANKS-1:0][LW-1:0]      ptr_q;
    logic [NUM_BANKS-1:0]              grant_v;
    logic [NUM_BANKS-1:0][LW-1:0]      grant_lane;
    logic [LW-1:0]                     scan_idx;
    logic [NUM_REQ-1:0]                lane_won;

    logic [NUM_REQ-1:0]                pend_v_q;
    logic [NUM_REQ-1:0]                pend_we_q;
    logic [NUM_REQ-1:0]                pend_err_q;
    logic [NUM_REQ-1:0][BW-1:0]        pend_bank_q;

    // Address decode; the two byte-offset bits are deliberately dropped.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            off[i]       = req_addr_i[i] - LOCAL_BASE;
            in_range[i]  = (req_addr_i[i] >= LOCAL_BASE) && (off[i] < WINDOW);
            lane_bank[i] = off[i][OW+BW-1:OW];
            lane_word[i] = off[i][OW-1:2];
            cand[i]      = '0;
            if (req_valid_i[i] && in_range[i]) begin
                cand[i][lane_bank[i]] = 1'b1;
            end
        end
    end

    // Round-robin per bank: first candidate at or above ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_v    = '0;
        grant_lane = '0;
        scan_idx   = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_idx = ptr_q[b] + LW'(k);
                if (!grant_v[b] && cand[scan_idx][b]) begin
                    grant_v[b]    = 1'b1;
                    grant_lane[b] = scan_idx;
                end
            end
        end
    end

    // Out-of-range lanes are accepted immediately so they never wait behind bank traffic.
    always_comb begin
        lane_won = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (grant_v[b]) begin
                lane_won[grant_lane[b]] = 1'b1;
            end
        end
        req_ready_o = lane_won | (req_valid_i & ~in_range);
    end

    always_comb begin
        bank_req_o   = grant_v;
        bank_we_o    = '0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        bank_be_o    = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (grant_v[b]) begin
                bank_we_o[b]    = req_we_i[grant_lane[b]];
                bank_addr_o[b]  = lane_word[grant_lane[b]];
                bank_wdata_o[b] = req_wdata_i[grant_lane[b]];
                bank_be_o[b]    = req_be_i[grant_lane[b]];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            pend_v_q    <= '0;
            pend_we_q   <= '0;
            pend_err_q  <= '0;
            pend_bank_q <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (grant_v[b]) begin
                    ptr_q[b] <= grant_lane[b] + LW'(1);
                end
            end
            pend_v_q   <= req_ready_o;
            pend_err_q <= req_valid_i & ~in_range;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready_o[i]) begin
                    pend_we_q[i]   <= req_we_i[i];
                    pend_bank_q[i] <= lane_bank[i];
                end
            end
        end
    end

    // Read data is steered only for successful reads; writes and errors return zero.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_rdata_o[i] = '0;
            if (pend_v_q[i] && !pend_we_q[i] && !pend_err_q[i]) begin
                rsp_rdata_o[i] = bank_rdata_i[pend_bank_q[i]];
            end
        end
    end

    assign rsp_valid_o = pend_v_q;
    assign rsp_err_o   = pend_err_q;

endmodule

// File: tb/tb_local_mem_bank_arbiter.sv
// Self-checking bench for local_mem_bank_arbiter: reference model of the memory map and
// round-robin rules, bank memory stubs, and a scoreboard drained by a response monitor.
module tb_local_mem_bank_arbiter;

    localparam int NR    = 4;
    localparam int NB    = 8;
    localparam int DW    = 32;
    localparam int WORDS = 2048;

    logic                  clk_i  = 1'b0;
    logic                  rst_ni = 1'b1;
    logic [NR-1:0]         req_valid_i = '0;
    logic [NR-1:0]         req_ready_o;
    logic [NR-1:0]         req_we_i = '0;
    logic [NR-1:0][31:0]   req_addr_i = '0;
    logic [NR-1:0][DW-1:0] req_wdata_i = '0;
    logic [NR-1:0][3:0]    req_be_i = '0;
    logic [NR-1:0]         rsp_valid_o;
    logic [NR-1:0][DW-1:0] rsp_rdata_o;
    logic [NR-1:0]         rsp_err_o;
    logic [NB-1:0]         bank_req_o;
    logic [NB-1:0]         bank_we_o;
    logic [NB-1:0][10:0]   bank_addr_o;
    logic [NB-1:0][DW-1:0] bank_wdata_o;
    logic [NB-1:0][3:0]    bank_be_o;
    logic [NB-1:0][DW-1:0] bank_rdata_i = '0;

    local_mem_bank_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .bank_req_o(bank_req_o), .bank_we_o(bank_we_o), .bank_addr_o(bank_addr_o),
        .bank_wdata_o(bank_wdata_o), .bank_be_o(bank_be_o), .bank_rdata_i(bank_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Bank macro stubs: single-port, 1-cycle read latency, junk on the data bus when not reading.
    logic [31:0] stub_mem  [NB][WORDS];
    logic [31:0] model_mem [NB][WORDS];

    always @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_req_o[b] && !bank_we_o[b]) bank_rdata_i[b] <= stub_mem[b][bank_addr_o[b]];
            else                                bank_rdata_i[b] <= $urandom;
            if (bank_req_o[b] && bank_we_o[b]) begin
                for (int k = 0; k < 4; k++) begin
                    if (bank_be_o[b][k]) stub_mem[b][bank_addr_o[b]][8*k +: 8] <= bank_wdata_o[b][8*k +: 8];
                end
            end
        end
    end

    // Reference model state: per-bank "next lane to favour" and pending responses per lane.
    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    int   rr [NB];
    rsp_t sbq[NR][$];

    logic [NR-1:0] cur_v  = '0;
    logic [NR-1:0] cur_we = '0;
    logic [31:0]   cur_addr  [NR];
    logic [31:0]   cur_wdata [NR];
    logic [3:0]    cur_be    [NR];

    function automatic void decode(input logic [31:0] a, output bit ok, output int bank, output int word);
        ok   = (a >= 32'h0002_0000) && (a <= 32'h0002_FFFF);
        bank = int'((a - 32'h0002_0000) / 32'h2000);
        word = int'(((a - 32'h0002_0000) % 32'h2000) / 4);
    endfunction

    task automatic set_req(input int i, input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        cur_v[i] = 1'b1; cur_we[i] = we; cur_addr[i] = a; cur_wdata[i] = d; cur_be[i] = be;
    endtask

    // One clock of traffic: drive lanes, predict acceptance and bank drive, push expected responses.
    task automatic run_cycle();
        logic [NR-1:0] acc;
        int            win [NB];
        int            best, d, bk, wd;
        bit            ok;
        rsp_t          r;
        @(posedge clk_i); #1;
        for (int i = 0; i < NR; i++) begin
            req_valid_i[i] = cur_v[i]; req_we_i[i] = cur_we[i]; req_addr_i[i] = cur_addr[i];
            req_wdata_i[i] = cur_wdata[i]; req_be_i[i] = cur_be[i];
        end
        #1;
        acc = '0;
        for (int b = 0; b < NB; b++) begin
            win[b] = -1;
            best   = NR;
            for (int i = 0; i < NR; i++) begin
                decode(cur_addr[i], ok, bk, wd);
                if (cur_v[i] && ok && bk == b) begin
                    d = (i - rr[b] + NR) % NR;
                    if (d < best) begin best = d; win[b] = i; end
                end
            end
            if (win[b] >= 0) acc[win[b]] = 1'b1;
        end
        for (int i = 0; i < NR; i++) begin
            decode(cur_addr[i], ok, bk, wd);
            if (cur_v[i] && !ok) acc[i] = 1'b1;
        end
        check("req_ready", 64'(req_ready_o), 64'(acc));
        for (int b = 0; b < NB; b++) begin
            check($sformatf("bank_req[%0d]", b), 64'(bank_req_o[b]), 64'(win[b] >= 0));
            if (win[b] >= 0) begin
                decode(cur_addr[win[b]], ok, bk, wd);
                check($sformatf("bank_we[%0d]", b), 64'(bank_we_o[b]), 64'(cur_we[win[b]]));
                check($sformatf("bank_addr[%0d]", b), 64'(bank_addr_o[b]), 64'(wd));
                check($sformatf("bank_be[%0d]", b), 64'(bank_be_o[b]), 64'(cur_be[win[b]]));
                if (cur_we[win[b]]) check($sformatf("bank_wdata[%0d]", b), 64'(bank_wdata_o[b]), 64'(cur_wdata[win[b]]));
            end else begin
                check($sformatf("bank_idle[%0d]", b),
                      64'({bank_we_o[b], bank_addr_o[b], bank_be_o[b]}) | 64'(bank_wdata_o[b]), 64'd0);
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                decode(cur_addr[i], ok, bk, wd);
                r.cyc   = cyc;
                r.err   = !ok;
                r.rdata = (ok && !cur_we[i]) ? model_mem[bk][wd] : 32'h0;
                sbq[i].push_back(r);
                if (ok && cur_we[i]) begin
                    for (int k = 0; k < 4; k++)
                        if (cur_be[i][k]) model_mem[bk][wd][8*k +: 8] = cur_wdata[i][8*k +: 8];
                end
                if (ok) rr[bk] = (i + 1) % NR;
                cur_v[i] = 1'b0;
            end
        end
    endtask

    // Response monitor: a response is due exactly one cycle after its acceptance.
    always @(negedge clk_i) begin
        rsp_t r;
        for (int i = 0; i < NR; i++) begin
            if (sbq[i].size() > 0 && sbq[i][0].cyc == cyc - 1) begin
                r = sbq[i].pop_front();
                check($sformatf("rsp_valid[%0d]", i), 64'(rsp_valid_o[i]), 64'd1);
                check($sformatf("rsp_err[%0d]", i), 64'(rsp_err_o[i]), 64'(r.err));
                check($sformatf("rsp_rdata[%0d]", i), 64'(rsp_rdata_o[i]), 64'(r.rdata));
            end else begin
                check($sformatf("rsp_quiet[%0d]", i),
                      64'({rsp_valid_o[i], rsp_err_o[i]}) | 64'(rsp_rdata_o[i]), 64'd0);
            end
        end
    end

    logic [31:0] bad_addr [6];
    int          bk_r, wd_r;
    logic [31:0] word_pick [4];

    initial begin
        bad_addr  = '{32'h0001_FFFC, 32'h0003_0000, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0001_FFFF, 32'h0003_FFFF};
        word_pick = '{32'd0, 32'd1, 32'd2, 32'd2047};
        for (int b = 0; b < NB; b++) begin
            rr[b] = 0;
            for (int w = 0; w < WORDS; w++) begin
                stub_mem[b][w]  = (w == 0) ? 32'hA0 + 32'(b) : {16'(b), 16'(w)} ^ 32'h5A5A_0000;
                model_mem[b][w] = stub_mem[b][w];
            end
        end
        for (int i = 0; i < NR; i++) begin cur_addr[i] = '0; cur_wdata[i] = '0; cur_be[i] = '0; end
        #1 rst_ni = 1'b0;
        #20;
        check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("reset_bank_req", 64'(bank_req_o), 64'd0);
        @(negedge clk_i) rst_ni = 1'b1;

        // Four lanes contend for bank 2: served one per cycle in lane order from ptr 0.
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'h0002_4000 + 32'(4 * i), 32'h0, 4'hF);
        for (int n = 0; n < NR; n++) begin
            run_cycle();
            check("bank2_grant", 64'(req_ready_o), 64'(1 << n));
            check("bank2_addr", 64'(bank_addr_o[2]), 64'(n));
        end
        run_cycle();

        // Four lanes hit four different banks in one cycle.
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'h0002_0000 + 32'(i) * 32'h2000, 32'h0, 4'hF);
        run_cycle();
        check("spread_ready", 64'(req_ready_o), 64'hF);
        check("spread_bank_req", 64'(bank_req_o), 64'h0F);
        for (int b = 0; b < NR; b++) check("spread_addr", 64'(bank_addr_o[b]), 64'd0);
        run_cycle();
        @(negedge clk_i);
        check("spread_rsp_valid", 64'(rsp_valid_o), 64'hF);
        for (int b = 0; b < NR; b++) check("spread_rdata", 64'(rsp_rdata_o[b]), 64'hA0 + 64'(b));

        // Top word of the window, partial write from lane 1.
        set_req(1, 1'b1, 32'h0002_FFFC, 32'hDEAD_BEEF, 4'b0011);
        run_cycle();
        check("top_bank_req", 64'(bank_req_o), 64'h80);
        check("top_we", 64'(bank_we_o[7]), 64'd1);
        check("top_addr", 64'(bank_addr_o[7]), 64'h7FF);
        check("top_be", 64'(bank_be_o[7]), 64'b0011);
        check("top_wdata", 64'(bank_wdata_o[7]), 64'hDEAD_BEEF);
        run_cycle();

        // Just outside both ends of the window, alongside a legal read.
        set_req(0, 1'b0, 32'h0003_0000, 32'h0, 4'hF);
        set_req(2, 1'b0, 32'h0001_FFFC, 32'h0, 4'hF);
        set_req(3, 1'b0, 32'h0002_0000, 32'h0, 4'hF);
        run_cycle();
        check("oob_ready", 64'(req_ready_o), 64'b1101);
        check("oob_bank_req", 64'(bank_req_o), 64'h01);
        run_cycle();
        @(negedge clk_i);
        check("oob_rsp_err", 64'(rsp_err_o), 64'b0101);
        check("oob_rsp_valid", 64'(rsp_valid_o), 64'b1101);

        // Lanes 0 and 3 hammer bank 5: grants must alternate.
        for (int n = 0; n < 8; n++) begin
            if (!cur_v[0]) set_req(0, 1'b0, 32'h0002_A000, 32'h0, 4'hF);
            if (!cur_v[3]) set_req(3, 1'b0, 32'h0002_A004, 32'h0, 4'hF);
            run_cycle();
            check("fair_grant", 64'(req_ready_o), (n % 2 == 0) ? 64'b0001 : 64'b1000);
        end
        for (int n = 0; n < NR && cur_v != '0; n++) run_cycle();
        run_cycle();

        // Reset in the cycle after a bank-4 grant to lane 2.
        set_req(2, 1'b0, 32'h0002_800C, 32'h0, 4'hF);
        run_cycle();
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        req_valid_i = '0;
        cur_v = '0;
        for (int i = 0; i < NR; i++) sbq[i].delete();
        for (int b = 0; b < NB; b++) rr[b] = 0;
        @(negedge clk_i);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_cycle();
        run_cycle();
        // Lane 3 would win if ptr[4] survived reset.
        set_req(0, 1'b0, 32'h0002_8000, 32'h0, 4'hF);
        set_req(3, 1'b0, 32'h0002_8004, 32'h0, 4'hF);
        run_cycle();
        check("post_rst_grant", 64'(req_ready_o), 64'b0001);
        run_cycle();
        run_cycle();

        // Random mixed traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!cur_v[i] && $urandom_range(0, 99) < 60) begin
                    if ($urandom_range(0, 9) < 8) begin
                        bk_r = $urandom_range(0, NB - 1);
                        wd_r = int'(word_pick[$urandom_range(0, 3)]);
                        set_req(i, 1'($urandom_range(0, 1)),
                                32'h0002_0000 + 32'(bk_r) * 32'h2000 + 32'(wd_r) * 4 + 32'($urandom_range(0, 3)),
                                $urandom, 4'($urandom_range(0, 15)));
                    end else begin
                        set_req(i, 1'($urandom_range(0, 1)), bad_addr[$urandom_range(0, 5)], $urandom, 4'hF);
                    end
                end
            end
            run_cycle();
        end
        for (int i = 0; i < NR; i++) cur_v[i] = 1'b0;
        repeat (4) run_cycle();
        @(negedge clk_i);
        for (int i = 0; i < NR; i++) check($sformatf("drain[%0d]", i), 64'(sbq[i].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
